// File: rtl/median_pkg.sv
// median_pkg: shared FSM states, window geometry and default controller run code.
package median_pkg;
    typedef enum logic [1:0] {IDLE, SORT, DONE} state_e;
    localparam int NUM_TAPS   = 9;
    localparam int MID_IDX    = 4;
    localparam int NUM_PHASES = 9;
    localparam logic [1:0] RUN_STATE_DEF = 2'd1;
endpackage

// File: rtl/median_filter_cmp_swap.sv
// cmp_swap: unsigned two-input min/max; equal inputs pass through unswapped.
module cmp_swap #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);
    assign lo = (b < a) ? b : a;
    assign hi = (b < a) ? a : b;
endmodule

// File: rtl/median_filter.sv
// median_filter: 3x3 median via a nine-phase odd-even transposition sort of a
// registered window, gated by the controller's enable and phase code.
module median_filter
    import median_pkg::*;
#(
    parameter int         DATA_W    = 8,
    parameter logic [1:0] RUN_STATE = RUN_STATE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1,
    input  logic [DATA_W-1:0] in_2,
    input  logic [DATA_W-1:0] in_3,
    input  logic [DATA_W-1:0] in_4,
    input  logic [DATA_W-1:0] in_5,
    input  logic [DATA_W-1:0] in_6,
    input  logic [DATA_W-1:0] in_7,
    input  logic [DATA_W-1:0] in_8,
    input  logic [1:0]        state,
    output logic [DATA_W-1:0] out_mid,
    output logic              filter_done
);
    state_e            state_q, state_d;
    logic [3:0]        phase_q, phase_d;
    logic [DATA_W-1:0] arr_q [NUM_TAPS];
    logic [DATA_W-1:0] arr_d [NUM_TAPS];
    logic [DATA_W-1:0] in_w  [NUM_TAPS];
    logic [DATA_W-1:0] swp   [NUM_TAPS];
    logic [DATA_W-1:0] ln_lo [4];
    logic [DATA_W-1:0] ln_hi [4];
    logic [DATA_W-1:0] out_mid_q, out_mid_d;
    logic              done_q, done_d;
    logic              go;

    assign go   = enable && (state == RUN_STATE);
    assign in_w = '{in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7, in_8};

    // Four shared lanes: even phases use pairs (2k,2k+1), odd phases (2k+1,2k+2).
    for (genvar k = 0; k < 4; k++) begin : g_lane
        cmp_swap #(.DATA_W(DATA_W)) u_cs (
            .a  (phase_q[0] ? arr_q[2*k+1] : arr_q[2*k]),
            .b  (phase_q[0] ? arr_q[2*k+2] : arr_q[2*k+1]),
            .lo (ln_lo[k]),
            .hi (ln_hi[k])
        );
    end

    always_comb begin
        swp = arr_q;
        for (int k = 0; k < 4; k++) begin
            if (phase_q[0]) begin
                swp[2*k+1] = ln_lo[k];
                swp[2*k+2] = ln_hi[k];
            end else begin
                swp[2*k]   = ln_lo[k];
                swp[2*k+1] = ln_hi[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        arr_d     = arr_q;
        out_mid_d = out_mid_q;
        done_d    = done_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (go) begin
                    arr_d   = in_w;
                    phase_d = '0;
                    state_d = SORT;
                end
            end
            SORT: begin
                done_d = 1'b0;
                if (!go) begin
                    state_d = IDLE;
                end else begin
                    arr_d   = swp;
                    phase_d = phase_q + 4'd1;
                    state_d = (phase_q == 4'(NUM_PHASES - 1)) ? DONE : SORT;
                end
            end
            DONE: begin
                done_d    = go;
                out_mid_d = go ? arr_q[MID_IDX] : out_mid_q;
                state_d   = go ? DONE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            out_mid_q <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) arr_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            out_mid_q <= out_mid_d;
            done_q    <= done_d;
            arr_q     <= arr_d;
        end
    end

    assign out_mid     = out_mid_q;
    assign filter_done = done_q;
endmodule

// File: tb/tb_median_filter.sv
// tb_median_filter: directed median-filter vectors with hand-computed medians.
module tb_median_filter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] state = 2'd0;
    logic [7:0] win [9];
    logic [7:0] v   [9];
    logic [7:0] out_mid;
    logic       filter_done;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    median_filter dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .in_0(win[0]), .in_1(win[1]), .in_2(win[2]), .in_3(win[3]), .in_4(win[4]),
        .in_5(win[5]), .in_6(win[6]), .in_7(win[7]), .in_8(win[8]),
        .state(state), .out_mid(out_mid), .filter_done(filter_done)
    );

    task automatic run_op(input logic [7:0] x [9], input logic [7:0] exp, input string name);
        bit early = 0;
        @(negedge clk);
        win = x; state = 2'd1; enable = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (filter_done !== 1'b0) early = 1;
        end
        vectors++;
        if (early) begin miscompares++; $display("FAIL %s_early_done: filter_done rose before edge 10", name); end
        @(posedge clk); #1;
        vectors++;
        if (filter_done !== 1'b1) begin miscompares++; $display("FAIL %s_done: got %b want 1", name, filter_done); end
        vectors++;
        if (out_mid !== exp) begin miscompares++; $display("FAIL %s_mid: got %0d want %0d", name, out_mid, exp); end
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1;
        vectors++;
        if (filter_done !== 1'b1 || out_mid !== exp) begin
            miscompares++; $display("FAIL %s_hold: done=%b mid=%0d want 1/%0d", name, filter_done, out_mid, exp);
        end
        @(negedge clk); enable = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (filter_done !== 1'b0 || out_mid !== exp) begin
            miscompares++; $display("FAIL %s_release: done=%b mid=%0d want 0/%0d", name, filter_done, out_mid, exp);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        win = '{default: 8'd0};
        #1;
        vectors++;
        if (out_mid !== 8'd0 || filter_done !== 1'b0) begin
            miscompares++; $display("FAIL reset: mid=%0d done=%b want 0/0", out_mid, filter_done);
        end
        #13 rst_n = 1'b1;
    endtask

    task automatic test_gating();
        logic [1:0] codes [3];
        bit bad;
        codes = '{2'd0, 2'd2, 2'd3};
        win = '{8'd15, 8'd30, 8'd20, 8'd1, 8'd0, 8'd2, 8'd4, 8'd3, 8'd3};
        for (int c = 0; c < 3; c++) begin
            bad = 0;
            @(negedge clk); state = codes[c]; enable = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (filter_done !== 1'b0 || out_mid !== 8'd0) bad = 1;
            end
            vectors++;
            if (bad) begin miscompares++; $display("FAIL gating_state%0d: done=%b mid=%0d want 0/0", codes[c], filter_done, out_mid); end
            @(negedge clk); enable = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic test_basic();
        v = '{8'd15, 8'd30, 8'd20, 8'd1, 8'd0, 8'd2, 8'd4, 8'd3, 8'd3};
        run_op(v, 8'd3, "basic");
    endtask

    task automatic test_extremes();
        v = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        run_op(v, 8'd4, "sorted");
        v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        run_op(v, 8'd4, "reverse");
        v = '{default: 8'd255};
        run_op(v, 8'd255, "all255");
        v = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
        run_op(v, 8'd0, "one255");
        v = '{8'd200, 8'd7, 8'd200, 8'd9, 8'd100, 8'd128, 8'd255, 8'd1, 8'd130};
        run_op(v, 8'd128, "unsigned");
    endtask

    task automatic test_abort_restart();
        bit bad = 0;
        @(negedge clk);
        win = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        state = 2'd1; enable = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1 enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (filter_done !== 1'b0 || out_mid !== 8'd128) bad = 1;
        end
        vectors++;
        if (bad) begin miscompares++; $display("FAIL abort: done=%b mid=%0d want 0/128", filter_done, out_mid); end
        v = '{8'd9, 8'd9, 8'd9, 8'd1, 8'd1, 8'd1, 8'd5, 8'd5, 8'd5};
        run_op(v, 8'd5, "restart");
    endtask

    task automatic test_input_change();
        bit early = 0;
        @(negedge clk);
        win = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
        state = 2'd1; enable = 1'b1;
        @(posedge clk);
        #2 win = '{default: 8'd200};
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (i == 4) win = '{default: 8'd3};
            if (filter_done !== 1'b0) early = 1;
        end
        @(posedge clk); #1;
        vectors++;
        if (early || filter_done !== 1'b1 || out_mid !== 8'd50) begin
            miscompares++; $display("FAIL input_change: done=%b mid=%0d want 1/50", filter_done, out_mid);
        end
        @(negedge clk); enable = 1'b0;
        @(posedge clk); @(posedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        win = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        state = 2'd1; enable = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_mid !== 8'd0 || filter_done !== 1'b0) begin
            miscompares++; $display("FAIL async_reset: mid=%0d done=%b want 0/0", out_mid, filter_done);
        end
        enable = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_mid !== 8'd0 || filter_done !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_idle: mid=%0d done=%b want 0/0", out_mid, filter_done);
        end
        v = '{8'd40, 8'd10, 8'd30, 8'd20, 8'd60, 8'd90, 8'd50, 8'd80, 8'd70};
        run_op(v, 8'd50, "after_reset");
    endtask

    initial begin
        test_reset();
        test_gating();
        test_basic();
        test_extremes();
        test_abort_restart();
        test_input_change();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
